// File: rtl/test_parameters_dump.sv
// rtl/test_parameters_dump.sv - streams the received parameter values as a byte frame and
// drives a replicated, optionally pipelined copy of input a.
module test_parameters_dump #(
  parameter int signed             AN_INT             = 0,
  parameter bit                    A_BOOL             = 1'b0,
  parameter bit                    A_BIT              = 1'b0,
  parameter int                    VEC_WIDTH          = 4,
  parameter logic [VEC_WIDTH-1:0]  A_BIT_VECTOR       = '0,
  parameter logic [VEC_WIDTH-1:0]  A_STD_LOGIC_VECTOR = '0,
  parameter int                    REPLICATE          = 2,
  parameter int                    PIPE_DEPTH         = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a,
  output logic [REPLICATE-1:0] b,
  input  logic                 start,
  output logic                 dump_valid,
  output logic [7:0]           dump_data,
  output logic                 dump_last,
  input  logic                 dump_ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int          NV        = (VEC_WIDTH + 7) / 8;
  localparam int          FRAME_LEN = 7 + 2 * NV;
  localparam logic [3:0]  LAST_IDX  = 4'(FRAME_LEN - 1);
  localparam logic [31:0] INT_BITS  = AN_INT;
  localparam logic [31:0] VEC_A     = 32'(A_BIT_VECTOR);
  localparam logic [31:0] VEC_B     = 32'(A_STD_LOGIC_VECTOR);

  // Every byte of the frame except the trailing checksum.
  function automatic logic [7:0] payload_byte(input int k);
    logic [31:0] word;
    word = 32'd0;
    if (k == 0)
      word = 32'h0000_00A5;
    else if (k <= 4)
      word = INT_BITS >> (8 * (k - 1));
    else if (k == 5)
      word = {30'd0, A_BIT, A_BOOL};
    else if (k < 6 + NV)
      word = VEC_A >> (8 * (k - 6));
    else if (k < 6 + 2 * NV)
      word = VEC_B >> (8 * (k - 6 - NV));
    return word[7:0];
  endfunction

  function automatic logic [7:0] frame_checksum();
    logic [7:0] acc;
    acc = 8'd0;
    for (int k = 0; k < FRAME_LEN - 1; k++)
      acc = acc ^ payload_byte(k);
    return acc;
  endfunction

  // The checksum is a pure function of the parameters, so no running XOR is kept.
  localparam logic [7:0] CHECKSUM = frame_checksum();

  function automatic logic [7:0] frame_byte(input logic [3:0] idx);
    if (idx == LAST_IDX)
      return CHECKSUM;
    return payload_byte(int'(idx));
  endfunction

  logic [1:0] state;
  logic [3:0] idx;
  logic [3:0] next_idx;

  assign next_idx = idx + 4'd1;
  assign busy     = (state == ST_SEND);
  assign done     = (state == ST_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= 4'd0;
      dump_valid <= 1'b0;
      dump_data  <= 8'h00;
      dump_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state      <= ST_SEND;
          idx        <= 4'd0;
          dump_valid <= 1'b1;
          dump_data  <= frame_byte(4'd0);
          dump_last  <= (LAST_IDX == 4'd0);
        end
        ST_SEND: begin
          if (dump_valid && dump_ready) begin
            if (idx == LAST_IDX) begin
              state      <= ST_DONE;
              dump_valid <= 1'b0;
              dump_data  <= 8'h00;
              dump_last  <= 1'b0;
            end else begin
              idx        <= next_idx;
              dump_data  <= frame_byte(next_idx);
              dump_last  <= (next_idx == LAST_IDX);
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            state      <= ST_SEND;
            idx        <= 4'd0;
            dump_valid <= 1'b1;
            dump_data  <= frame_byte(4'd0);
            dump_last  <= (LAST_IDX == 4'd0);
          end
        end
        default: begin
          state      <= ST_IDLE;
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
        end
      endcase
    end
  end

  // One bit per stage is enough; replication happens at the output.
  generate
    if (PIPE_DEPTH == 0) begin : g_comb
      assign b = {REPLICATE{a}};
    end else begin : g_pipe
      logic [PIPE_DEPTH-1:0] stage;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          stage <= '0;
        end else begin
          stage[0] <= a;
          for (int i = 1; i < PIPE_DEPTH; i++)
            stage[i] <= stage[i-1];
        end
      end
      assign b = {REPLICATE{stage[PIPE_DEPTH-1]}};
    end
  endgenerate

endmodule

// File: tb/tb_test_parameters_dump.sv
// tb/tb_test_parameters_dump.sv - directed bench for test_parameters_dump with default,
// overridden and pipeline-variant instances.
module tb_test_parameters_dump;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic a;

  logic       start_d, ready_d, valid_d, last_d, busy_d, done_d;
  logic [7:0] data_d;
  logic [1:0] b_d;

  logic       start_o, ready_o, valid_o, last_o, busy_o, done_o;
  logic [7:0] data_o;
  logic [1:0] b_o;

  logic       start_p, ready_p, valid_p, last_p, busy_p, done_p;
  logic [7:0] data_p;
  logic [2:0] b_p;

  logic       start_z, ready_z, valid_z, last_z, busy_z, done_z;
  logic [7:0] data_z;
  logic [2:0] b_z;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_def [9]  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
  logic [7:0] exp_ovr [11] = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h03, 8'hBC, 8'h0A, 8'hF0, 8'h00, 8'hE8};

  test_parameters_dump u_def (
    .clock(clock), .reset_n(reset_n), .a(a), .b(b_d), .start(start_d),
    .dump_valid(valid_d), .dump_data(data_d), .dump_last(last_d), .dump_ready(ready_d),
    .busy(busy_d), .done(done_d)
  );

  test_parameters_dump #(
    .AN_INT(32'h12345678), .A_BOOL(1'b1), .A_BIT(1'b1), .VEC_WIDTH(12),
    .A_BIT_VECTOR(12'hABC), .A_STD_LOGIC_VECTOR(12'h0F0)
  ) u_ovr (
    .clock(clock), .reset_n(reset_n), .a(a), .b(b_o), .start(start_o),
    .dump_valid(valid_o), .dump_data(data_o), .dump_last(last_o), .dump_ready(ready_o),
    .busy(busy_o), .done(done_o)
  );

  test_parameters_dump #(.REPLICATE(3), .PIPE_DEPTH(2)) u_p2 (
    .clock(clock), .reset_n(reset_n), .a(a), .b(b_p), .start(start_p),
    .dump_valid(valid_p), .dump_data(data_p), .dump_last(last_p), .dump_ready(ready_p),
    .busy(busy_p), .done(done_p)
  );

  test_parameters_dump #(.REPLICATE(3), .PIPE_DEPTH(0)) u_p0 (
    .clock(clock), .reset_n(reset_n), .a(a), .b(b_z), .start(start_z),
    .dump_valid(valid_z), .dump_data(data_z), .dump_last(last_z), .dump_ready(ready_z),
    .busy(busy_z), .done(done_z)
  );

  // Leaves reset released #1 after an edge; the next edge is edge 1.
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    a = 1'b1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (valid_d !== 1'b0 || data_d !== 8'h00 || last_d !== 1'b0 || busy_d !== 1'b0 || done_d !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b data=%h last=%b busy=%b done=%b expected all zero",
               valid_d, data_d, last_d, busy_d, done_d);
    end
    total++;
    if (b_p !== 3'b000 || b_d !== 2'b00) begin
      bad++;
      $display("FAIL reset_b: b_p=%b b_d=%b expected 000 and 00", b_p, b_d);
    end
    total++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovr: valid=%b busy=%b expected 0 0", valid_o, busy_o);
    end
    a = 1'b0;
  endtask

  task automatic test_default_frame();
    ready_d = 1'b1;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(posedge clock); #1;
      total++;
      if (valid_d !== 1'b1 || data_d !== exp_def[k] || last_d !== (k == 8) || busy_d !== 1'b1) begin
        bad++;
        $display("FAIL default_byte%0d: valid=%b data=%h last=%b busy=%b expected 1 %h %b 1",
                 k, valid_d, data_d, last_d, busy_d, exp_def[k], (k == 8));
      end
    end
    @(posedge clock); #1;
    total++;
    if (valid_d !== 1'b0 || last_d !== 1'b0 || busy_d !== 1'b0 || done_d !== 1'b1) begin
      bad++;
      $display("FAIL default_end: valid=%b last=%b busy=%b done=%b expected 0 0 0 1",
               valid_d, last_d, busy_d, done_d);
    end
  endtask

  task automatic test_override_frame();
    ready_o = 1'b1;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      @(posedge clock); #1;
      total++;
      if (valid_o !== 1'b1 || data_o !== exp_ovr[k] || last_o !== (k == 10)) begin
        bad++;
        $display("FAIL override_byte%0d: valid=%b data=%h last=%b expected 1 %h %b",
                 k, valid_o, data_o, last_o, exp_ovr[k], (k == 10));
      end
    end
    @(posedge clock); #1;
    total++;
    if (valid_o !== 1'b0 || done_o !== 1'b1) begin
      bad++;
      $display("FAIL override_end: valid=%b done=%b expected 0 1", valid_o, done_o);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pat;
    logic        stall;
    logic [7:0]  hold_d;
    logic        hold_l;
    int          got;
    pat   = 16'b0110_1011_0010_1100;
    stall = 1'b0;
    hold_d = 8'h00;
    hold_l = 1'b0;
    got   = 0;
    ready_o = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 100 && got < 11; cyc++) begin
      @(posedge clock); #1;
      if (stall) begin
        total++;
        if (valid_o !== 1'b1 || data_o !== hold_d || last_o !== hold_l) begin
          bad++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b expected 1 %h %b",
                   valid_o, data_o, last_o, hold_d, hold_l);
        end
      end
      ready_o = pat[cyc % 16];
      if (valid_o && ready_o) begin
        total++;
        if (data_o !== exp_ovr[got] || last_o !== (got == 10)) begin
          bad++;
          $display("FAIL bp_byte%0d: data=%h last=%b expected %h %b",
                   got, data_o, last_o, exp_ovr[got], (got == 10));
        end
        got++;
        stall = 1'b0;
      end else begin
        stall  = valid_o;
        hold_d = data_o;
        hold_l = last_o;
      end
    end
    total++;
    if (got != 11) begin
      bad++;
      $display("FAIL bp_count: got %0d bytes expected 11", got);
    end
    @(posedge clock); #1;
    total++;
    if (valid_o !== 1'b0 || done_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_end: valid=%b done=%b expected 0 1", valid_o, done_o);
    end
  endtask

  task automatic test_restart();
    ready_d = 1'b1;
    start_d = 1'b0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(posedge clock); #1;
      total++;
      if (valid_d !== 1'b1 || data_d !== exp_def[k] || last_d !== (k == 8)) begin
        bad++;
        $display("FAIL busy_start_byte%0d: valid=%b data=%h last=%b expected 1 %h %b",
                 k, valid_d, data_d, last_d, exp_def[k], (k == 8));
      end
      start_d = (k >= 1 && k <= 6);
    end
    repeat (2) begin
      @(posedge clock); #1;
      total++;
      if (done_d !== 1'b1 || valid_d !== 1'b0 || busy_d !== 1'b0) begin
        bad++;
        $display("FAIL done_hold: done=%b valid=%b busy=%b expected 1 0 0", done_d, valid_d, busy_d);
      end
    end
    start_d = 1'b1;
    @(posedge clock); #1;
    start_d = 1'b0;
    total++;
    if (valid_d !== 1'b1 || data_d !== 8'hA5 || busy_d !== 1'b1 || done_d !== 1'b0) begin
      bad++;
      $display("FAIL restart_first: valid=%b data=%h busy=%b done=%b expected 1 a5 1 0",
               valid_d, data_d, busy_d, done_d);
    end
    for (int k = 1; k < 9; k++) begin
      @(posedge clock); #1;
      total++;
      if (valid_d !== 1'b1 || data_d !== exp_def[k] || last_d !== (k == 8)) begin
        bad++;
        $display("FAIL restart_byte%0d: valid=%b data=%h last=%b expected 1 %h %b",
                 k, valid_d, data_d, last_d, exp_def[k], (k == 8));
      end
    end
    @(posedge clock); #1;
    total++;
    if (done_d !== 1'b1 || valid_d !== 1'b0) begin
      bad++;
      $display("FAIL restart_end: done=%b valid=%b expected 1 0", done_d, valid_d);
    end
  endtask

  task automatic test_midframe_reset();
    ready_d = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      total++;
      if (valid_d !== 1'b1 || data_d !== exp_def[k]) begin
        bad++;
        $display("FAIL pre_reset_byte%0d: valid=%b data=%h expected 1 %h", k, valid_d, data_d, exp_def[k]);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (valid_d !== 1'b0 || data_d !== 8'h00 || last_d !== 1'b0 || busy_d !== 1'b0 || done_d !== 1'b0) begin
      bad++;
      $display("FAIL midframe_reset: valid=%b data=%h last=%b busy=%b done=%b expected all zero",
               valid_d, data_d, last_d, busy_d, done_d);
    end
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clock); #1;
      total++;
      if (valid_d !== 1'b1 || data_d !== exp_def[k] || last_d !== (k == 8)) begin
        bad++;
        $display("FAIL post_reset_byte%0d: valid=%b data=%h last=%b expected 1 %h %b",
                 k, valid_d, data_d, last_d, exp_def[k], (k == 8));
      end
    end
    @(posedge clock); #1;
    total++;
    if (done_d !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_end: done=%b expected 1", done_d);
    end
  endtask

  task automatic test_pipeline();
    logic       apat [6];
    logic [2:0] exp_p;
    logic [1:0] exp_d;
    apat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    a = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      exp_p = (i >= 2) ? {3{apat[i-2]}} : 3'b000;
      exp_d = (i >= 1) ? {2{apat[i-1]}} : 2'b00;
      total++;
      if (b_p !== exp_p) begin
        bad++;
        $display("FAIL pipe2_cycle%0d: b=%b expected %b", i, b_p, exp_p);
      end
      total++;
      if (b_d !== exp_d) begin
        bad++;
        $display("FAIL pipe1_cycle%0d: b=%b expected %b", i, b_d, exp_d);
      end
      a = apat[i];
      #1;
      total++;
      if (b_z !== {3{apat[i]}}) begin
        bad++;
        $display("FAIL pipe0_cycle%0d: b=%b expected %b", i, b_z, {3{apat[i]}});
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a       = 1'b0;
    start_d = 1'b0; ready_d = 1'b0;
    start_o = 1'b0; ready_o = 1'b0;
    start_p = 1'b0; ready_p = 1'b1;
    start_z = 1'b0; ready_z = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_default_frame();
    test_override_frame();
    test_backpressure();
    test_restart();
    test_midframe_reset();
    test_pipeline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
